// File: rtl/csi_pkg.sv
// Shared types and constants for the CSI-2 payload/CRC feeder.
// Byte lane 3 is earliest on the wire, lane 0 latest.
package csi_pkg;

    typedef logic [3:0][7:0] byte_lanes_t;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CRC_TAIL
    } feeder_state_t;

    localparam logic [5:0]  LONG_DT_MIN  = 6'h10;
    localparam logic [15:0] CSI_CRC_SEED = 16'hFFFF;

endpackage

// File: rtl/csi_payload_crc_feeder.sv
// CSI-2 packet parser: header decode, payload strip and CRC extraction,
// producing the control stream for the downstream CRC-16 checker.
module csi_payload_crc_feeder
    import csi_pkg::*;
#(
    parameter logic [5:0] LONG_DT_MIN = csi_pkg::LONG_DT_MIN,
    parameter bit         GAP_CHECK   = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  byte_lanes_t data_i,
    input  logic        valid_i,
    input  logic        sop_i,
    output byte_lanes_t pld_data_o,
    output logic        pld_valid_o,
    output logic [1:0]  pld_bytes_o,
    output logic        pld_last_o,
    output logic [5:0]  pkt_dt_o,
    output logic [15:0] pkt_wc_o,
    output logic        short_valid_o,
    output logic        crc_init_o,
    output byte_lanes_t crc_data_o,
    output logic [1:0]  crc_last_sel_o,
    output logic        crc_capture_o,
    output logic [15:0] rx_crc_o,
    output logic        rx_crc_valid_o,
    output logic        zero_wc_err_o,
    output logic        trunc_err_o,
    output logic        gap_err_o
);

    feeder_state_t state;
    logic [15:0]   rem;
    logic          zero_wc;
    logic          half_tail;
    logic [7:0]    lsb_q;

    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        open_pkt;
    logic        last_word;
    logic [1:0]  last_sel;
    logic [15:0] take;
    logic [15:0] rem_next;
    logic [15:0] tail_crc;
    logic [15:0] inword_crc;

    assign hdr_dt   = data_i[3][5:0];
    assign hdr_wc   = {data_i[1], data_i[2]};
    assign open_pkt = (state != IDLE);

    assign last_word = (rem <= 16'd4);
    assign last_sel  = last_word ? 2'(rem[1:0] - 2'd1) : 2'd3;
    assign take      = last_word ? rem : 16'd4;
    assign rem_next  = (rem > take) ? (rem - take) : 16'd0;

    // A 3-byte final word leaves only the LSB behind; the MSB follows in lane 3.
    assign tail_crc   = half_tail ? {data_i[3], lsb_q}
                                  : {data_i[2], data_i[3]};
    assign inword_crc = (last_sel == 2'd0) ? {data_i[1], data_i[2]}
                                           : {data_i[0], data_i[1]};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state          <= IDLE;
            rem            <= '0;
            zero_wc        <= 1'b0;
            half_tail      <= 1'b0;
            lsb_q          <= '0;
            pld_data_o     <= '0;
            pld_valid_o    <= 1'b0;
            pld_bytes_o    <= '0;
            pld_last_o     <= 1'b0;
            pkt_dt_o       <= '0;
            pkt_wc_o       <= '0;
            short_valid_o  <= 1'b0;
            crc_init_o     <= 1'b0;
            crc_data_o     <= '0;
            crc_last_sel_o <= '0;
            crc_capture_o  <= 1'b0;
            rx_crc_o       <= '0;
            rx_crc_valid_o <= 1'b0;
            zero_wc_err_o  <= 1'b0;
            trunc_err_o    <= 1'b0;
            gap_err_o      <= 1'b0;
        end else begin
            pld_valid_o    <= 1'b0;
            pld_last_o     <= 1'b0;
            short_valid_o  <= 1'b0;
            crc_init_o     <= 1'b0;
            crc_capture_o  <= 1'b0;
            rx_crc_valid_o <= 1'b0;
            zero_wc_err_o  <= 1'b0;
            trunc_err_o    <= 1'b0;
            gap_err_o      <= 1'b0;

            if (valid_i && sop_i) begin
                trunc_err_o <= open_pkt;
                pkt_dt_o    <= hdr_dt;
                pkt_wc_o    <= hdr_wc;
                half_tail   <= 1'b0;
                if (hdr_dt < LONG_DT_MIN) begin
                    short_valid_o <= 1'b1;
                    zero_wc       <= 1'b0;
                    rem           <= '0;
                    state         <= IDLE;
                end else begin
                    crc_init_o <= 1'b1;
                    rem        <= hdr_wc;
                    zero_wc    <= (hdr_wc == 16'd0);
                    state      <= (hdr_wc == 16'd0) ? CRC_TAIL : PAYLOAD;
                end
            end else if (open_pkt && !valid_i) begin
                if (GAP_CHECK) begin
                    gap_err_o <= 1'b1;
                    rem       <= '0;
                    state     <= IDLE;
                end
            end else if (valid_i) begin
                case (state)
                    PAYLOAD: begin
                        pld_valid_o    <= 1'b1;
                        pld_data_o     <= data_i;
                        crc_data_o     <= data_i;
                        pld_bytes_o    <= last_sel;
                        crc_last_sel_o <= last_sel;
                        rem            <= rem_next;
                        if (last_word) begin
                            pld_last_o    <= 1'b1;
                            crc_capture_o <= 1'b1;
                            if (last_sel <= 2'd1) begin
                                rx_crc_o       <= inword_crc;
                                rx_crc_valid_o <= 1'b1;
                                state          <= IDLE;
                            end else begin
                                half_tail <= (last_sel == 2'd2);
                                lsb_q     <= data_i[0];
                                state     <= CRC_TAIL;
                            end
                        end
                    end
                    CRC_TAIL: begin
                        if (zero_wc) begin
                            zero_wc_err_o <= (tail_crc != CSI_CRC_SEED);
                        end else begin
                            rx_crc_o       <= tail_crc;
                            rx_crc_valid_o <= 1'b1;
                        end
                        zero_wc   <= 1'b0;
                        half_tail <= 1'b0;
                        state     <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csi_payload_crc_feeder.sv
// Randomised bench: packets are expanded into a byte stream and the
// expected per-cycle outputs are derived from byte positions in it.
module tb_csi_payload_crc_feeder;
    import csi_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    byte_lanes_t data_i = '0;
    logic        valid_i = 1'b0;
    logic        sop_i = 1'b0;
    byte_lanes_t pld_data_o;
    logic        pld_valid_o;
    logic [1:0]  pld_bytes_o;
    logic        pld_last_o;
    logic [5:0]  pkt_dt_o;
    logic [15:0] pkt_wc_o;
    logic        short_valid_o;
    logic        crc_init_o;
    byte_lanes_t crc_data_o;
    logic [1:0]  crc_last_sel_o;
    logic        crc_capture_o;
    logic [15:0] rx_crc_o;
    logic        rx_crc_valid_o;
    logic        zero_wc_err_o;
    logic        trunc_err_o;
    logic        gap_err_o;

    csi_payload_crc_feeder dut (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i),
        .valid_i(valid_i), .sop_i(sop_i),
        .pld_data_o(pld_data_o), .pld_valid_o(pld_valid_o),
        .pld_bytes_o(pld_bytes_o), .pld_last_o(pld_last_o),
        .pkt_dt_o(pkt_dt_o), .pkt_wc_o(pkt_wc_o),
        .short_valid_o(short_valid_o), .crc_init_o(crc_init_o),
        .crc_data_o(crc_data_o), .crc_last_sel_o(crc_last_sel_o),
        .crc_capture_o(crc_capture_o), .rx_crc_o(rx_crc_o),
        .rx_crc_valid_o(rx_crc_valid_o), .zero_wc_err_o(zero_wc_err_o),
        .trunc_err_o(trunc_err_o), .gap_err_o(gap_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        pv;
        logic        pl;
        logic        sv;
        logic        ci;
        logic        cc;
        logic        rv;
        logic        ze;
        logic        te;
        logic        ge;
        logic [1:0]  pb;
        logic [31:0] pd;
        logic [15:0] rc;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    bit          open_pkt = 0;
    logic [5:0]  exp_dt = '0;
    logic [15:0] exp_wc = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] d, input bit v, input bit s,
                        input bit r, input exp_t e);
        @(negedge clk_i);
        data_i  = d;
        valid_i = v;
        sop_i   = s;
        reset_i = r;
        @(posedge clk_i);
        #1;
        chk("pld_valid", 32'(pld_valid_o), 32'(e.pv));
        chk("pld_last", 32'(pld_last_o), 32'(e.pl));
        chk("short_valid", 32'(short_valid_o), 32'(e.sv));
        chk("crc_init", 32'(crc_init_o), 32'(e.ci));
        chk("crc_capture", 32'(crc_capture_o), 32'(e.cc));
        chk("rx_crc_valid", 32'(rx_crc_valid_o), 32'(e.rv));
        chk("zero_wc_err", 32'(zero_wc_err_o), 32'(e.ze));
        chk("trunc_err", 32'(trunc_err_o), 32'(e.te));
        chk("gap_err", 32'(gap_err_o), 32'(e.ge));
        chk("pkt_dt", 32'(pkt_dt_o), 32'(exp_dt));
        chk("pkt_wc", 32'(pkt_wc_o), 32'(exp_wc));
        if (e.pv) begin
            chk("pld_data", pld_data_o, e.pd);
            chk("crc_data", crc_data_o, e.pd);
            chk("pld_bytes", 32'(pld_bytes_o), 32'(e.pb));
            chk("crc_last_sel", 32'(crc_last_sel_o), 32'(e.pb));
        end
        if (e.rv) chk("rx_crc", 32'(rx_crc_o), 32'(e.rc));
        if (r) begin
            chk("rst_pld_data", pld_data_o, 32'h0);
            chk("rst_crc_data", crc_data_o, 32'h0);
            chk("rst_rx_crc", 32'(rx_crc_o), 32'h0);
            chk("rst_bytes", 32'({pld_bytes_o, crc_last_sel_o}), 32'h0);
        end
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        e = '0;
        exp_dt = '0;
        exp_wc = '0;
        open_pkt = 0;
        for (int i = 0; i < n; i++) step($urandom, 1'b1, 1'b0, 1'b1, e);
    endtask

    task automatic idle(input int n);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++)
            step($urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, e);
    endtask

    // abort_w: stop before that word (packet left open); gap_w: drop valid there
    task automatic send_pkt(input logic [5:0] dt, input logic [15:0] wc,
                            input logic [15:0] crc, input int abort_w,
                            input int gap_w, input bit pat);
        logic [7:0]  s[$];
        logic [7:0]  vc;
        logic [31:0] word;
        exp_t        e;
        int          nw;
        int          k;
        for (int i = 0; i < int'(wc); i++)
            s.push_back(pat ? 8'(i + 1) : 8'($urandom));
        s.push_back(crc[7:0]);
        s.push_back(crc[15:8]);
        while (s.size() % 4 != 0) s.push_back(8'($urandom));
        nw = s.size() / 4;

        vc = 8'($urandom_range(0, 3));
        e = '0;
        e.te = open_pkt;
        exp_dt = dt;
        exp_wc = wc;
        if (dt < 6'h10) e.sv = 1'b1;
        else e.ci = 1'b1;
        step({vc[1:0], dt, wc[7:0], wc[15:8], 8'($urandom)},
             1'b1, 1'b1, 1'b0, e);
        if (dt < 6'h10) begin
            open_pkt = 0;
            return;
        end
        open_pkt = 1;

        for (int w = 0; w < nw; w++) begin
            if (w == abort_w) return;
            if (w == gap_w) begin
                e = '0;
                e.ge = 1'b1;
                step($urandom, 1'b0, 1'b0, 1'b0, e);
                open_pkt = 0;
                return;
            end
            word = {s[4*w], s[4*w+1], s[4*w+2], s[4*w+3]};
            e = '0;
            if (4 * w < int'(wc)) begin
                k = int'(wc) - 4 * w;
                if (k > 4) k = 4;
                e.pv = 1'b1;
                e.pd = word;
                e.pb = 2'(k - 1);
                e.pl = (4 * w + 4 >= int'(wc));
                e.cc = e.pl;
            end
            if (wc != 0 && w == (int'(wc) + 1) / 4) begin
                e.rv = 1'b1;
                e.rc = crc;
            end
            if (wc == 0 && w == 0) e.ze = (crc != 16'hFFFF);
            step(word, 1'b1, 1'b0, 1'b0, e);
        end
        open_pkt = 0;
    endtask

    initial begin
        int r;
        do_reset(2);
        send_pkt(6'h2A, 16'd8, 16'hBEEF, -1, -1, 1'b1);
        idle(2);
        send_pkt(6'h2B, 16'd6, 16'hA5C3, -1, -1, 1'b0);
        send_pkt(6'h2C, 16'd7, 16'h1357, -1, -1, 1'b0);
        send_pkt(6'h2C, 16'd5, 16'h2468, -1, -1, 1'b0);
        send_pkt(6'h2A, 16'd0, 16'hFFFF, -1, -1, 1'b0);
        send_pkt(6'h2A, 16'd0, 16'h1234, -1, -1, 1'b0);
        idle(1);
        send_pkt(6'h00, 16'd5, 16'h0, -1, -1, 1'b0);
        send_pkt(6'h2A, 16'd16, 16'h0F0F, 1, -1, 1'b0);
        send_pkt(6'h2A, 16'd4, 16'h7777, -1, -1, 1'b0);
        send_pkt(6'h2A, 16'd12, 16'h4242, -1, 2, 1'b0);
        idle(2);
        send_pkt(6'h2A, 16'd20, 16'h9999, 2, -1, 1'b0);
        do_reset(1);
        idle(1);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            send_pkt(6'($urandom_range(0, 63)), 16'($urandom_range(0, 40)),
                     16'($urandom), (r == 0 || r == 2) ? $urandom_range(0, 3) : -1,
                     (r == 1) ? $urandom_range(0, 3) : -1, 1'b0);
            if (r == 2 && open_pkt) do_reset(1);
            if (!open_pkt) idle($urandom_range(0, 2));
        end
        if (open_pkt) do_reset(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
